// File: rtl/mem_bus_arbiter_if.sv
// Bundle of BIU-side beat handshakes and the shared memory port around the arbiter.
// master = BIUs plus memory (environment), slave = the arbiter itself.
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 32,
    parameter int DW      = 32
);
    logic [NUM_REQ-1:0]    arb_req;
    logic [NUM_REQ*AW-1:0] arb_addr;
    logic [NUM_REQ*DW-1:0] arb_wdata;
    logic [NUM_REQ-1:0]    arb_we;
    logic [NUM_REQ-1:0]    arb_vld;
    logic [NUM_REQ-1:0]    arb_rdy;
    logic [DW-1:0]         arb_rdata;
    logic [NUM_REQ-1:0]    arb_rvld;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic                  mem_we;
    logic                  mem_vld;
    logic                  mem_rdy;
    logic [DW-1:0]         mem_rdata;
    logic                  mem_rvld;

    modport master (
        output arb_req, arb_addr, arb_wdata, arb_we, arb_vld, mem_rdy, mem_rdata, mem_rvld,
        input  arb_rdy, arb_rdata, arb_rvld, arb_gnt, mem_addr, mem_wdata, mem_we, mem_vld
    );

    modport slave (
        input  arb_req, arb_addr, arb_wdata, arb_we, arb_vld, mem_rdy, mem_rdata, mem_rvld,
        output arb_rdy, arb_rdata, arb_rvld, arb_gnt, mem_addr, mem_wdata, mem_we, mem_vld
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin burst arbiter for the single accelerator memory port (imap/weight/omap BIUs).
// Grant is held per burst; reads are drained before ownership moves so returns need no tagging.
module mem_bus_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_OUTS = 8
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_OUTS) + 1;

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t             state;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      last;
    logic [IW-1:0]      pick;
    logic               pick_vld;
    logic [CW-1:0]      outs_cnt;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] own_oh;
    logic               own_req;
    logic               own_vld;
    logic               own_we;
    logic               stall;
    logic               fwd;
    logic               rd_inc;
    logic               rd_dec;
    logic               drain_done;

    // Scan starts just after the last served requester, so each waiter is reached within NUM_REQ bursts.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!pick_vld && bus.arb_req[idx]) begin
                pick     = IW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign own_oh  = NUM_REQ'(1) << owner;
    assign own_req = bus.arb_req[owner];
    assign own_vld = bus.arb_vld[owner];
    assign own_we  = bus.arb_we[owner];

    // Only reads are throttled by the outstanding limit; a dropped req blocks the same-cycle beat.
    assign stall = ~own_we & (outs_cnt == CW'(MAX_OUTS));
    assign fwd   = (state == GRANT) & own_req & ~stall;

    assign bus.mem_vld   = fwd & own_vld;
    assign bus.arb_rdy   = (fwd & bus.mem_rdy) ? own_oh : '0;
    assign bus.mem_we    = (state == GRANT) & own_we;
    assign bus.mem_addr  = (state == GRANT) ? bus.arb_addr[owner*AW +: AW] : '0;
    assign bus.mem_wdata = (state == GRANT) ? bus.arb_wdata[owner*DW +: DW] : '0;
    assign bus.arb_gnt   = gnt;

    assign bus.arb_rvld  = ((state != IDLE) && bus.mem_rvld) ? own_oh : '0;
    assign bus.arb_rdata = (state != IDLE) ? bus.mem_rdata : '0;

    assign rd_inc     = bus.mem_vld & bus.mem_rdy & ~bus.mem_we;
    assign rd_dec     = bus.mem_rvld & (outs_cnt != '0);
    assign drain_done = (outs_cnt == '0) & ~bus.mem_rvld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            last     <= IW'(NUM_REQ - 1);
            outs_cnt <= '0;
        end else begin
            case ({rd_inc, rd_dec})
                2'b10:   outs_cnt <= outs_cnt + 1'b1;
                2'b01:   outs_cnt <= outs_cnt - 1'b1;
                default: ;
            endcase
            case (state)
                IDLE: if (pick_vld) begin
                    owner <= pick;
                    gnt   <= NUM_REQ'(1) << pick;
                    state <= GRANT;
                end
                GRANT: if (!own_req) state <= DRAIN;
                DRAIN: if (drain_done) begin
                    last  <= owner;
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a transaction-level ownership/outstanding model
// plus a latency memory model check every cycle, with directed phases layered on top.
module tb_mem_bus_arbiter;
    localparam int N    = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

    mem_bus_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .MAX_OUTS(MAXO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: who owns the port, whether the burst is ending, reads in flight
    int m_owner = -1;
    bit m_rel   = 1'b0;
    int m_last  = N - 1;
    int m_outs  = 0;
    int own_beats = 0;
    int glog[$];
    // memory model: in-order read returns, at least 2 cycles after acceptance
    int unsigned mq_due[$];
    logic [DW-1:0] mq_dat[$];
    int unsigned cyc = 0;

    logic [AW-1:0] b_addr [N];
    logic [DW-1:0] b_data [N];
    bit            b_we   [N];
    int            b_cnt  [N];

    int mode = 2;
    logic [N-1:0] fix_mask = '0;
    int p_tog = 5, p_vld = 80, p_rdy = 100, p_ret = 100, p_we = 50;
    bit hold_ret = 1'b0;
    int stall_seen = 0, simul = 0, rd_acc_dut = 0, wr_acc_dut = 0;
    logic [N-1:0] prev_gnt = '0;

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic new_beat(input int i);
        b_cnt[i]++;
        b_addr[i] = (32'(i) << 24) | 32'(b_cnt[i]);
        b_data[i] = $urandom;
        b_we[i]   = ($urandom_range(99) < p_we);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_rel   = 1'b0;
        m_last  = N - 1;
        m_outs  = 0;
        mq_due.delete();
        mq_dat.delete();
    endtask

    task automatic step(input bit do_rst);
        logic [N-1:0] oh, req;
        bit act, stl, emv, acc, ret;
        int o, sz, p;
        @(negedge clk);
        rst = do_rst;
        o = m_owner;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       if ($urandom_range(99) < p_tog) bus.arb_req[i] = ~bus.arb_req[i];
                1:       bus.arb_req[i] = !(i == o && !m_rel && own_beats >= 3);
                default: bus.arb_req[i] = fix_mask[i];
            endcase
            bus.arb_vld[i] = ($urandom_range(99) < p_vld);
            bus.arb_we[i]  = b_we[i];
            bus.arb_addr[i*AW +: AW]  = b_addr[i];
            bus.arb_wdata[i*DW +: DW] = b_data[i];
        end
        bus.mem_rdy = ($urandom_range(99) < p_rdy);
        if (!hold_ret && mq_dat.size() > 0 && mq_due[0] <= cyc && $urandom_range(99) < p_ret) begin
            bus.mem_rvld  = 1'b1;
            bus.mem_rdata = mq_dat[0];
        end else begin
            bus.mem_rvld  = 1'b0;
            bus.mem_rdata = '0;
        end
        #1;
        req = bus.arb_req;
        ret = bus.mem_rvld;
        oh = '0; act = 0; stl = 0;
        if (o >= 0) begin
            oh  = N'(1) << o;
            act = !m_rel && req[o];
            stl = !b_we[o] && (m_outs == MAXO);
        end
        emv = act && !stl && bus.arb_vld[o];
        acc = emv && bus.mem_rdy;
        chk("gnt", bus.arb_gnt, oh);
        chk("mem_vld", bus.mem_vld, emv);
        chk("arb_rdy", bus.arb_rdy, (act && !stl && bus.mem_rdy) ? oh : '0);
        chk("arb_rvld", bus.arb_rvld, (o >= 0 && ret) ? oh : '0);
        if (emv) begin
            chk("mem_addr", bus.mem_addr, b_addr[o]);
            chk("mem_we", bus.mem_we, b_we[o]);
            if (b_we[o]) chk("mem_wdata", bus.mem_wdata, b_data[o]);
        end
        if (o >= 0 && ret) chk("arb_rdata", bus.arb_rdata, mq_dat[0]);
        if (bus.arb_gnt != '0 && prev_gnt != '0 && bus.arb_gnt != prev_gnt)
            chk("gnt_gap", prev_gnt, '0);
        prev_gnt = bus.arb_gnt;
        if (bus.mem_vld && bus.mem_rdy) begin
            if (bus.mem_we) wr_acc_dut++;
            else            rd_acc_dut++;
        end
        if (do_rst) begin
            model_reset();
        end else begin
            if (bus.mem_vld && bus.mem_rdy && !bus.mem_we) begin
                mq_due.push_back(cyc + 2);
                mq_dat.push_back(bus.mem_addr ^ 32'h5a5a_0000);
            end
            if (ret) begin
                void'(mq_due.pop_front());
                void'(mq_dat.pop_front());
            end
            sz = m_outs;
            if (stl) stall_seen++;
            if (acc) begin
                if (!b_we[o]) begin
                    m_outs++;
                    if (ret && sz > 0) simul++;
                end
                own_beats++;
                new_beat(o);
            end
            if (ret && sz > 0) m_outs--;
            if (o < 0) begin
                p = rr_pick(req, m_last);
                if (p >= 0) begin
                    m_owner = p; m_rel = 1'b0; own_beats = 0;
                    glog.push_back(p);
                end
            end else if (!m_rel) begin
                if (!req[o]) m_rel = 1'b1;
            end else if (sz == 0 && !ret) begin
                m_last = o; m_owner = -1;
            end
        end
        cyc++;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        mode = 2; fix_mask = '0; hold_ret = 1'b0; p_ret = 100;
        for (int k = 0; k < 300 && !done; k++) begin
            step(1'b0);
            done = (m_owner < 0) && (m_outs == 0) && (mq_dat.size() == 0);
        end
        chk("idle_wait", done, 1'b1);
    endtask

    initial begin
        bus.arb_req = '1; bus.arb_vld = '0; bus.arb_we = '0;
        bus.arb_addr = '0; bus.arb_wdata = '0;
        bus.mem_rdy = 1'b1; bus.mem_rvld = 1'b0; bus.mem_rdata = '0;
        for (int i = 0; i < N; i++) new_beat(i);
        for (int i = 0; i < N; i++) begin
            bus.arb_addr[i*AW +: AW]  = b_addr[i];
            bus.arb_wdata[i*DW +: DW] = b_data[i];
        end
        // reset with all three requests already high
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        model_reset();
        chk("rst_gnt", bus.arb_gnt, '0);
        chk("rst_mem_vld", bus.mem_vld, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, '0);
        chk("rst_mem_wdata", bus.mem_wdata, '0);
        chk("rst_arb_rdata", bus.arb_rdata, '0);
        chk("rst_arb_rdy", bus.arb_rdy, '0);
        chk("rst_arb_rvld", bus.arb_rvld, '0);

        // fairness: every requester keeps asking, each burst ends after 3 beats
        mode = 1; fix_mask = '1;
        repeat (200) step(1'b0);
        chk("rr_cnt", glog.size() >= 6, 1'b1);
        for (int k = 0; k < 6 && k < glog.size(); k++) chk("rr_order", glog[k], k % N);

        // general random traffic
        mode = 0; p_tog = 5; p_vld = 70; p_rdy = 70; p_ret = 60; p_we = 40;
        repeat (1500) step(1'b0);

        // outstanding limit with memory returns frozen
        wait_idle();
        hold_ret = 1'b1; p_we = 0; p_vld = 100; p_rdy = 100;
        for (int i = 0; i < N; i++) new_beat(i);
        mode = 2; fix_mask = 3'b001; rd_acc_dut = 0;
        repeat (30) step(1'b0);
        chk("outs_lim", rd_acc_dut, MAXO);
        p_we = 60; wr_acc_dut = 0;
        new_beat(0);
        repeat (20) step(1'b0);
        chk("wr_at_full", wr_acc_dut > 0, 1'b1);
        hold_ret = 1'b0; p_ret = 50; p_we = 30;
        repeat (40) step(1'b0);

        // reset in the middle of an omap write burst; imap must win afterwards
        wait_idle();
        p_we = 100; for (int i = 0; i < N; i++) new_beat(i);
        mode = 2; fix_mask = 3'b100;
        repeat (10) step(1'b0);
        fix_mask = '1;
        glog.delete();
        step(1'b1);
        repeat (5) step(1'b0);
        chk("rst_prio_cnt", glog.size() > 0, 1'b1);
        if (glog.size() > 0) chk("rst_prio", glog[0], 0);

        // random traffic with occasional resets
        mode = 0; p_tog = 6; p_vld = 75; p_rdy = 65; p_ret = 55; p_we = 35;
        for (int k = 0; k < 1000; k++) step($urandom_range(299) == 0);

        chk("stall_seen", stall_seen > 0, 1'b1);
        chk("simul_inc_dec", simul > 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
